// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Instruction-memory and data-memory handshake bundle between
//               the instruction sequencer (master) and the memories (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    // Instruction fetch channel
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            imem_ack;

    // Data access channel
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle control FSM around the 8-bit opcode decoder.
//               Fetches an opcode, classifies the decoder's one-hot result,
//               steps ALU / data memory / register-file enables and advances
//               the PC. One instruction in flight.
// Options     : SEQ_TIMEOUT_EN - when defined, FETCH/MEM give up after
//               TIMEOUT_CYC cycles without an ack and enter FAULT. The
//               TIMEOUT_CYC parameter only exists in that build.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [26:0]     LOAD_MASK   = 27'h0000002,
    parameter logic [26:0]     STORE_MASK  = 27'h0000004,
    parameter logic [26:0]     BRANCH_MASK = 27'h0078000,
    parameter logic [26:0]     HALT_MASK   = 27'h0000001
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYC = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    instr_sequencer_if.master    bus,
    output logic [7:0]           opcode_out,
    input  logic [26:0]          dec_y,
    output logic                 alu_en,
    input  logic                 br_taken,
    input  logic [PC_W-1:0]      br_target,
    output logic                 rf_we,
    output logic                 retire,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_HALT   = 3'd6;
    localparam logic [2:0] c_FAULT  = 3'd7;

    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [26:0]     c_DEC_ONE = 27'd1;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic [7:0]      r_ir;
    logic            r_is_store;
    logic            r_is_branch;

    logic            w_onehot;
    logic            w_dec_halt;
    logic            w_dec_load;
    logic            w_dec_store;
    logic            w_dec_branch;
    logic            w_branch_exec;
    logic            w_retire;
    logic            w_tmo_expire;

    // A legal decode has exactly one bit set: nonzero and clearing the
    // lowest set bit leaves nothing behind.
    assign w_onehot     = (dec_y != 27'd0) && ((dec_y & (dec_y - c_DEC_ONE)) == 27'd0);
    assign w_dec_halt   = |(dec_y & HALT_MASK);
    assign w_dec_load   = |(dec_y & LOAD_MASK);
    assign w_dec_store  = |(dec_y & STORE_MASK);
    assign w_dec_branch = |(dec_y & BRANCH_MASK);

    assign w_pc_inc      = r_pc + c_PC_ONE;
    assign w_branch_exec = (r_state == c_EXEC) && r_is_branch;
    assign w_retire      = w_branch_exec
                         || ((r_state == c_MEM) && r_is_store && bus.dmem_ack)
                         || (r_state == c_WB);

`ifdef SEQ_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_waiting;

    assign w_waiting = (r_state == c_FETCH) || (r_state == c_MEM);

    // Count cycles spent waiting for an ack; restart on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_waiting || (w_state_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Expiry only matters when no ack arrives; the FSM checks ack first
    assign w_tmo_expire = w_waiting && (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_tmo_expire = 1'b0;
`endif

    // Next-state selection; HALT and FAULT only leave through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_next = c_FETCH;
            end
            c_FETCH: begin
                if (bus.imem_ack)       w_state_next = c_DECODE;
                else if (w_tmo_expire)  w_state_next = c_FAULT;
            end
            c_DECODE: begin
                if (!w_onehot)                        w_state_next = c_FAULT;
                else if (w_dec_halt)                  w_state_next = c_HALT;
                else if (w_dec_load || w_dec_store)   w_state_next = c_MEM;
                else                                  w_state_next = c_EXEC;
            end
            c_EXEC: begin
                w_state_next = r_is_branch ? c_FETCH : c_WB;
            end
            c_MEM: begin
                if (bus.dmem_ack)       w_state_next = r_is_store ? c_FETCH : c_WB;
                else if (w_tmo_expire)  w_state_next = c_FAULT;
            end
            c_WB: begin
                w_state_next = c_FETCH;
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter: branch target or sequential increment on retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_branch_exec) begin
            r_pc <= br_taken ? br_target : w_pc_inc;
        end else if (w_retire) begin
            r_pc <= w_pc_inc;
        end
    end

    // Instruction register captures the opcode when the fetch completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= 8'h00;
        end else if ((r_state == c_FETCH) && bus.imem_ack) begin
            r_ir <= bus.imem_rdata;
        end
    end

    // Remember the instruction class so EXEC/MEM need not re-sample dec_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
        end else if (r_state == c_DECODE) begin
            r_is_store  <= w_dec_store;
            r_is_branch <= w_dec_branch;
        end
    end

    assign bus.imem_req  = (r_state == c_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = (r_state == c_MEM);
    assign bus.dmem_we   = (r_state == c_MEM) && r_is_store;

    assign opcode_out = r_ir;
    assign alu_en     = (r_state == c_EXEC);
    assign rf_we      = (r_state == c_WB);
    assign retire     = w_retire;
    assign pc         = r_pc;
    assign busy       = (r_state != c_IDLE) && (r_state != c_HALT) && (r_state != c_FAULT);
    assign halted     = (r_state == c_HALT);
    assign fault      = (r_state == c_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. Directed programs
//               are loaded into a behavioural instruction memory; each test
//               queues its expected retirements and a monitor compares them
//               as the sequencer retires instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int c_PC_W = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        br_taken  = 1'b0;
    logic [7:0]  br_target = 8'h00;

    logic [7:0]  opcode_out;
    logic [26:0] dec_y;
    logic        alu_en;
    logic        rf_we;
    logic        retire;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fault;

    instr_sequencer_if #(.PC_W(c_PC_W)) ifc ();

    instr_sequencer #(.PC_W(c_PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (ifc),
        .opcode_out (opcode_out),
        .dec_y      (dec_y),
        .alu_en     (alu_en),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .rf_we      (rf_we),
        .retire     (retire),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory and decoder models
    // ------------------------------------------------------------------
    logic [7:0] imem [0:255];
    logic       imem_en   = 1'b1;
    int         imem_wait = 0;
    int         dmem_wait = 0;
    int         imem_cnt;
    int         dmem_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               imem_cnt <= 0;
        else if (!ifc.imem_req || ifc.imem_ack)   imem_cnt <= 0;
        else                                      imem_cnt <= imem_cnt + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               dmem_cnt <= 0;
        else if (!ifc.dmem_req || ifc.dmem_ack)   dmem_cnt <= 0;
        else                                      dmem_cnt <= dmem_cnt + 1;
    end

    assign ifc.imem_ack   = ifc.imem_req && imem_en && (imem_cnt >= imem_wait);
    assign ifc.imem_rdata = imem[ifc.imem_addr];
    assign ifc.dmem_ack   = ifc.dmem_req && (dmem_cnt >= dmem_wait);

    function automatic logic [26:0] dec_model(input logic [7:0] op);
        case (op)
            8'h00:   return 27'h0000001;   // halt
            8'h01:   return 27'h0000002;   // load
            8'h02:   return 27'h0000004;   // store
            8'h0F:   return 27'h0008000;   // branch
            8'h10:   return 27'h0000008;   // ALU
            8'hEF:   return 27'h0000003;   // two bits: illegal
            default: return 27'h0000000;   // no bits: illegal
        endcase
    endfunction

    assign dec_y = dec_model(opcode_out);

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       rf_we;
        logic [7:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic got_rf;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && retire) begin
                got_rf = rf_we;
                @(posedge clk);
                #1;
                check("retire_was_expected", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("retire_rf_we", got_rf, e.rf_we);
                    check("retire_pc", pc, e.pc);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        start     = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
        imem_en   = 1'b1;
        imem_wait = 0;
        dmem_wait = 0;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        tick(2);
        check("sb_drained", sb_q.size(), 0);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge of FETCH cycle 1
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int k;
        k = 0;
        while (!halted && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_halted"}, halted, 1'b1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        int n_req;
        int n_we;
        int n_rf;

        // Reset state
        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_imem_addr", ifc.imem_addr, 8'h00);
        check("rst_opcode", opcode_out, 8'h00);
        check("rst_ctrl", {ifc.imem_req, ifc.dmem_req, ifc.dmem_we, alu_en, rf_we, retire}, 6'b0);
        check("rst_status", {busy, halted, fault}, 3'b0);

        // ALU instruction, zero-wait acks
        imem[0] = 8'h10;
        sb_q.push_back('{rf_we: 1'b1, pc: 8'h01});
        pulse_start();
        check("alu_c1_fetch", {ifc.imem_req, busy}, 2'b11);
        tick(2);
        check("alu_c3_alu_en", {alu_en, rf_we}, 2'b10);
        tick(1);
        check("alu_c4_wb", {alu_en, rf_we, retire}, 3'b011);
        wait_halted("alu");
        check("halt_pc_held", pc, 8'h01);
        pulse_start();
        tick(3);
        check("halt_start_ignored", {halted, busy, ifc.imem_req}, 3'b100);
        check("halt_pc_after_start", pc, 8'h01);

        // Store with two wait cycles on dmem_ack
        do_reset();
        imem[0]   = 8'h02;
        dmem_wait = 2;
        sb_q.push_back('{rf_we: 1'b0, pc: 8'h01});
        pulse_start();
        n_we = 0; n_rf = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.dmem_req && ifc.dmem_we) n_we++;
            if (rf_we) n_rf++;
            tick(1);
        end
        check("store_req_we_cycles", n_we, 3);
        check("store_no_rf_we", n_rf, 0);
        wait_halted("store");

        // Load, zero-wait
        do_reset();
        imem[0] = 8'h01;
        sb_q.push_back('{rf_we: 1'b1, pc: 8'h01});
        pulse_start();
        n_req = 0; n_we = 0; n_rf = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.dmem_req) n_req++;
            if (ifc.dmem_we) n_we++;
            if (rf_we) n_rf++;
            tick(1);
        end
        check("load_req_cycles", n_req, 1);
        check("load_we_cycles", n_we, 0);
        check("load_rf_we_cycles", n_rf, 1);
        wait_halted("load");

        // Branch taken to 0x40
        do_reset();
        imem[0]    = 8'h0F;
        br_taken   = 1'b1;
        br_target  = 8'h40;
        sb_q.push_back('{rf_we: 1'b0, pc: 8'h40});
        pulse_start();
        tick(2);
        check("br_t_c3", {alu_en, retire}, 2'b11);
        tick(1);
        check("br_t_fetch_req", ifc.imem_req, 1'b1);
        check("br_t_fetch_addr", ifc.imem_addr, 8'h40);
        wait_halted("br_t");

        // Branch not taken
        do_reset();
        imem[0]    = 8'h0F;
        br_taken   = 1'b0;
        br_target  = 8'h40;
        sb_q.push_back('{rf_we: 1'b0, pc: 8'h01});
        pulse_start();
        tick(3);
        check("br_nt_fetch_addr", ifc.imem_addr, 8'h01);
        wait_halted("br_nt");

        // Illegal decodes: no bits and two bits
        for (int t = 0; t < 2; t++) begin
            do_reset();
            imem[0] = (t == 0) ? 8'hEE : 8'hEF;
            pulse_start();
            tick(2);
            check("illegal_fault_status", {fault, busy, halted}, 3'b100);
            pulse_start();
            tick(4);
            check("illegal_fault_sticky", {fault, ifc.imem_req}, 2'b10);
            check("illegal_pc", pc, 8'h00);
        end

        // Halt as the first instruction
        do_reset();
        pulse_start();
        tick(2);
        check("halt_first_status", {halted, busy, fault}, 3'b100);
        pulse_start();
        tick(3);
        check("halt_first_sticky", {halted, ifc.imem_req}, 2'b10);
        check("halt_first_pc", pc, 8'h00);

        // pc wrap: branch to 0xFF, ALU there, then a not-taken branch at 0
        do_reset();
        imem[0]    = 8'h0F;
        imem[8'hFF] = 8'h10;
        br_taken   = 1'b1;
        br_target  = 8'hFF;
        sb_q.push_back('{rf_we: 1'b0, pc: 8'hFF});
        sb_q.push_back('{rf_we: 1'b1, pc: 8'h00});
        sb_q.push_back('{rf_we: 1'b0, pc: 8'h01});
        pulse_start();
        n_req = 0;
        while (!(ifc.imem_req && ifc.imem_addr == 8'hFF) && n_req < 20) begin
            tick(1);
            n_req++;
        end
        check("wrap_reached_ff", ifc.imem_addr, 8'hFF);
        br_taken = 1'b0;
        wait_halted("wrap");
        check("wrap_final_pc", pc, 8'h01);

        // Reset asserted in the middle of a stalled fetch
        do_reset();
        imem[0] = 8'h10;
        sb_q.push_back('{rf_we: 1'b1, pc: 8'h01});
        pulse_start();
        tick(3);
        imem_en = 1'b0;
        tick(1);
        check("stall_fetch_req", ifc.imem_req, 1'b1);
        check("stall_fetch_addr", ifc.imem_addr, 8'h01);
`ifndef SEQ_TIMEOUT_EN
        tick(20);
        check("stall_wait_forever", {ifc.imem_req, fault}, 2'b10);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req_drop", ifc.imem_req, 1'b0);
        check("async_rst_pc", pc, 8'h00);
        check("async_rst_busy", busy, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        // Fetch never acknowledged
        do_reset();
        imem[0] = 8'h10;
        imem_en = 1'b0;
        pulse_start();
        tick(15);
        check("tmo_c16_waiting", {ifc.imem_req, fault}, 2'b10);
        tick(1);
        check("tmo_c17_fault", {ifc.imem_req, fault, busy}, 3'b010);

        // Ack on the last allowed cycle wins over expiry
        do_reset();
        imem[0]   = 8'h10;
        imem_wait = 15;
        sb_q.push_back('{rf_we: 1'b1, pc: 8'h01});
        pulse_start();
        tick(15);
        check("tmo_ack_c16", {ifc.imem_req, ifc.imem_ack}, 2'b11);
        tick(1);
        check("tmo_ack_c17_decode", {fault, busy}, 2'b01);
        wait_halted("tmo_ack");
`endif

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
